multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU main control FSM (Moore, fetch/decode/execute sequencing).
// Define MULTICYCLE_JUMP_EN to add the JUMP state for opcode 0x02.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OpJ     = 6'h02;
`endif

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10
`ifdef MULTICYCLE_JUMP_EN
    ,
    StJump   = 4'd11
`endif
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d       = StFetch;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    aluop         = 2'd0;
    pc_source     = 2'd0;
    illegal       = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_b = 2'd3;
        case (opcode)
          OpRtype:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq:       state_d = StBranch;
          OpAddi:      state_d = StAddiEx;
`ifdef MULTICYCLE_JUMP_EN
          OpJ:         state_d = StJump;
`endif
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = mem_ready ? StFetch : StMemWr;
      end
      StExec: begin
        alu_src_a = 1'b1;
        aluop     = 2'd2;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        aluop         = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
`endif
      default: state_d = StFetch;
    endcase

    // Reset must never let a write strobe or illegal escape, even mid-instruction.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      illegal       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle state/output expectations.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, aluop, pc_source;
  logic [3:0] state;

  localparam logic [3:0] F = 4'd0, DEC = 4'd1, MADR = 4'd2, MRD = 4'd3, MWB = 4'd4, MWR = 4'd5;
  localparam logic [3:0] EXE = 4'd6, AWB = 4'd7, BR = 4'd8, AIEX = 4'd9, AIWB = 4'd10, JMP = 4'd11;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .aluop        (aluop),
    .pc_source    (pc_source),
    .illegal      (illegal),
    .state        (state)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] outs;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Expected output vector per state, taken from the state/output table.
  function automatic logic [16:0] ref_outs(input logic [3:0] st, input logic mr,
                                           input logic rst, input logic ill);
    logic pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'd0; aop = 2'd0; pcs = 2'd0;
    case (st)
      F:    begin mrd = 1'b1; asb = 2'd1; irw = mr; pcw = mr; end
      DEC:  asb = 2'd3;
      MADR: begin asa = 1'b1; asb = 2'd2; end
      MRD:  begin mrd = 1'b1; iod = 1'b1; end
      MWB:  begin rw = 1'b1; m2r = 1'b1; end
      MWR:  begin mwr = 1'b1; iod = 1'b1; end
      EXE:  begin asa = 1'b1; aop = 2'd2; end
      AWB:  begin rw = 1'b1; rdst = 1'b1; end
      BR:   begin asa = 1'b1; aop = 2'd1; pcc = 1'b1; pcs = 2'd1; end
      AIEX: begin asa = 1'b1; asb = 2'd2; end
      AIWB: rw = 1'b1;
      JMP:  begin pcw = 1'b1; pcs = 2'd2; end
      default: ;
    endcase
    if (rst) {pcw, pcc, mrd, mwr, irw, rw} = '0;
    return {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
  endfunction

  // Drive one cycle's inputs and queue the expected response for that cycle.
  task automatic step(input logic rst, input logic [5:0] opc, input logic mr,
                      input logic [3:0] st, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = opc;
    mem_ready = mr;
    e.st      = st;
    e.outs    = ref_outs(st, mr, rst, ill);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] act;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, aluop, pc_source, illegal};
      total++;
      if (state !== e.st || act !== e.outs) begin
        bad++;
        $display("FAIL cycle%0d: got state=%0d outs=%b, want state=%0d outs=%b",
                 total, state, act, e.st, e.outs);
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    // Held in reset: FETCH with every strobe suppressed
    step(1'b1, 6'h00, 1'b1, F, 1'b0);
    // lw, with mem_ready low in MEMADR to show it is ignored there
    step(1'b0, 6'h23, 1'b1, F,    1'b0);
    step(1'b0, 6'h23, 1'b1, DEC,  1'b0);
    step(1'b0, 6'h23, 1'b0, MADR, 1'b0);
    step(1'b0, 6'h23, 1'b1, MRD,  1'b0);
    step(1'b0, 6'h23, 1'b0, MWB,  1'b0);
    // sw: one fetch wait, then three MEMWR wait cycles
    step(1'b0, 6'h2B, 1'b0, F,    1'b0);
    step(1'b0, 6'h2B, 1'b1, F,    1'b0);
    step(1'b0, 6'h2B, 1'b1, DEC,  1'b0);
    step(1'b0, 6'h2B, 1'b1, MADR, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 6'h2B, 1'b0, MWR, 1'b0);
    step(1'b0, 6'h2B, 1'b1, MWR,  1'b0);
    // R-type
    step(1'b0, 6'h00, 1'b1, F,    1'b0);
    step(1'b0, 6'h00, 1'b0, DEC,  1'b0);
    step(1'b0, 6'h00, 1'b0, EXE,  1'b0);
    step(1'b0, 6'h00, 1'b0, AWB,  1'b0);
    // beq
    step(1'b0, 6'h04, 1'b1, F,    1'b0);
    step(1'b0, 6'h04, 1'b1, DEC,  1'b0);
    step(1'b0, 6'h04, 1'b1, BR,   1'b0);
    // addi
    step(1'b0, 6'h08, 1'b1, F,    1'b0);
    step(1'b0, 6'h08, 1'b1, DEC,  1'b0);
    step(1'b0, 6'h08, 1'b1, AIEX, 1'b0);
    step(1'b0, 6'h08, 1'b1, AIWB, 1'b0);
    // Unsupported opcode: single illegal pulse, back to FETCH
    step(1'b0, 6'h3F, 1'b1, F,    1'b0);
    step(1'b0, 6'h3F, 1'b1, DEC,  1'b1);
    // Jump opcode
    step(1'b0, 6'h02, 1'b1, F,    1'b0);
`ifdef MULTICYCLE_JUMP_EN
    step(1'b0, 6'h02, 1'b1, DEC,  1'b0);
    step(1'b0, 6'h02, 1'b1, JMP,  1'b0);
`else
    step(1'b0, 6'h02, 1'b1, DEC,  1'b1);
`endif
    // Reset while waiting in MEMRD: no MEMWB / reg_write afterwards
    step(1'b0, 6'h23, 1'b1, F,    1'b0);
    step(1'b0, 6'h23, 1'b1, DEC,  1'b0);
    step(1'b0, 6'h23, 1'b1, MADR, 1'b0);
    step(1'b0, 6'h23, 1'b0, MRD,  1'b0);
    step(1'b1, 6'h23, 1'b0, MRD,  1'b0);
    step(1'b0, 6'h3F, 1'b0, F,    1'b0);
    step(1'b0, 6'h3F, 1'b1, F,    1'b0);
    step(1'b0, 6'h3F, 1'b1, DEC,  1'b1);
    step(1'b0, 6'h00, 1'b0, F,    1'b0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
